mem_responder: RTL and testbench

Synthesizable memory-side responder for the `eightbit` core's memory bus, replacing the behavioral array in the bench. It accepts the core's `mem_req`/`we`/`addr` request, drives or captures the bidirectional `data` bus, and signals completion on `mem_ready` after a programmable number of wait states. It provides 256×8 storage, plus a side port for preload and inspection by test harnesses.

---
 rtl/mem_responder_pkg.sv | 15 +
 rtl/mem_responder_if.sv | 26 ++
 rtl/mem_responder_mem_array.sv | 43 ++++
 rtl/mem_responder.sv | 124 ++++++++++++
 tb/tb_mem_responder.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the eightbit memory-bus responder: bus widths,
// wait-counter width and FSM state encoding.
package mem_responder_pkg;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Core-side request/handshake signals plus the harness side port.
// The tristate data bus is a separate net on the responder itself.
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic              we;
    logic              mem_req;
    logic              mem_ready;
    logic              abort_err;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [DATA_W-1:0] dbg_rdata;

    modport master (
        output addr, we, mem_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_ready, abort_err, dbg_rdata
    );

    modport slave (
        input  addr, we, mem_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_ready, abort_err, dbg_rdata
    );

endinterface

// File: rtl/mem_responder_mem_array.sv
// 256x8 storage: prioritized bus/debug write ports, registered bus read,
// combinational debug read.
module mem_array
    import mem_responder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_we_i,
    input  logic              bus_re_i,
    input  logic [ADDR_W-1:0] bus_addr_i,
    input  logic [DATA_W-1:0] bus_wdata_i,
    output logic [DATA_W-1:0] bus_rdata_o,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic [DATA_W-1:0] dbg_rdata_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Bus write is issued last so it overrides a debug write to the same address.
    always_ff @(posedge clk) begin
        if (dbg_we_i) begin
            mem[dbg_addr_i] <= dbg_wdata_i;
        end
        if (bus_we_i) begin
            mem[bus_addr_i] <= bus_wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (bus_re_i) begin
            rdata_q <= mem[bus_addr_i];
        end
    end

    assign bus_rdata_o = rdata_q;
    assign dbg_rdata_o = mem[dbg_addr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the eightbit core: request FSM, wait-state
// counter, request latches, tristate data driver and sticky abort flag.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_responder_if.slave         bus,
    inout  wire logic [DATA_W-1:0] data
);

    state_e                state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  abort_q, abort_d;

    logic                  commit;
    logic                  commit_we;
    logic [ADDR_W-1:0]     commit_addr;
    logic [DATA_W-1:0]     commit_data;
    logic [DATA_W-1:0]     rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        abort_d     = abort_q;
        commit      = 1'b0;
        commit_we   = we_q;
        commit_addr = addr_q;
        commit_data = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus.mem_req) begin
                    addr_d = bus.addr;
                    we_d   = bus.we;
                    if (bus.we) begin
                        wdata_d = data;
                    end
                    // Zero wait states: the capture edge is also the commit edge,
                    // so the array sees the live request rather than the latches.
                    if (WAIT_STATES == 0) begin
                        state_d     = S_READY;
                        commit      = 1'b1;
                        commit_we   = bus.we;
                        commit_addr = bus.addr;
                        commit_data = data;
                    end else begin
                        cnt_d   = WAIT_CNT_W'(WAIT_STATES);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!bus.mem_req) begin
                    state_d = S_IDLE;
                    abort_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == WAIT_CNT_W'(1)) begin
                        state_d = S_READY;
                        commit  = 1'b1;
                    end
                end
            end
            S_READY: begin
                if (!bus.mem_req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An edge that coincides with reset must not commit a pending access.
        if (rst) begin
            commit = 1'b0;
        end
    end

    mem_array u_mem_array (
        .clk         (clk),
        .rst         (rst),
        .bus_we_i    (commit && commit_we),
        .bus_re_i    (commit && !commit_we),
        .bus_addr_i  (commit_addr),
        .bus_wdata_i (commit_data),
        .bus_rdata_o (rdata),
        .dbg_we_i    (bus.dbg_we),
        .dbg_addr_i  (bus.dbg_addr),
        .dbg_wdata_i (bus.dbg_wdata),
        .dbg_rdata_o (bus.dbg_rdata)
    );

    assign bus.mem_ready = (state_q == S_READY);
    assign bus.abort_err = abort_q;
    assign data = (state_q == S_READY && !we_q) ? rdata : 'z;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: five instances (WAIT_STATES 0,2,3,4,5)
// share one stimulus driver; a negedge monitor checks each mem_ready rise.
module tb_mem_responder;

    typedef struct {
        bit         rd;
        logic [7:0] val;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] addr = '0;
    logic       we = 1'b0;
    logic       mem_req = 1'b0;
    logic       dbg_we = 1'b0;
    logic [7:0] dbg_addr = '0;
    logic [7:0] dbg_wdata = '0;
    logic [7:0] tb_dq = '0;
    logic       tb_doe = 1'b0;
    int         sel = 0;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    exp_t       sb[$];

    wire [4:0]  rdy_v;
    wire [4:0]  abort_v;
    wire [7:0]  drd_v  [5];
    wire [7:0]  dobs_v [5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance k has WAIT_STATES 0,2,3,4,5 for k = 0..4.
    for (genvar k = 0; k < 5; k++) begin : g_dut
        wire [7:0] d;
        mem_responder_if bus ();

        assign bus.addr      = addr;
        assign bus.we        = we;
        assign bus.mem_req   = mem_req && (sel == k);
        assign bus.dbg_we    = dbg_we && (sel == k);
        assign bus.dbg_addr  = dbg_addr;
        assign bus.dbg_wdata = dbg_wdata;
        assign d             = (tb_doe && sel == k) ? tb_dq : 'z;

        assign rdy_v[k]   = bus.mem_ready;
        assign abort_v[k] = bus.abort_err;
        assign drd_v[k]   = bus.dbg_rdata;
        assign dobs_v[k]  = d;

        mem_responder #(.WAIT_STATES((k == 0) ? 0 : k + 1)) dut (
            .clk  (clk),
            .rst  (rst),
            .bus  (bus),
            .data (d)
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int idx(input int w);
        return (w == 0) ? 0 : w - 1;
    endfunction

    // Monitor: every rising mem_ready pops one expected response.
    logic rprev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rdy_v[sel] && !rprev) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ready: mem_ready got 1 expected 0 (inst %0d)", sel);
            end else begin
                e = sb.pop_front();
                chk("ready_latency", cyc, e.cyc);
                chk(e.rd ? "read_data" : "write_bus_data", dobs_v[sel], e.val);
            end
        end
        rprev = rdy_v[sel];
    end

    task automatic dbg_write(input int w, input logic [7:0] a, input logic [7:0] v);
        sel = idx(w);
        @(negedge clk);
        dbg_addr  = a;
        dbg_wdata = v;
        dbg_we    = 1'b1;
        @(negedge clk);
        dbg_we = 1'b0;
        chk("dbg_write", drd_v[sel], v);
    endtask

    task automatic access(input int w, input bit wr, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] exp_rd, input bit col, input logic [7:0] cold);
        sel = idx(w);
        @(negedge clk);
        addr      = a;
        we        = wr;
        tb_dq     = d;
        tb_doe    = wr;
        dbg_addr  = a;
        dbg_wdata = cold;
        dbg_we    = col;
        mem_req   = 1'b1;
        sb.push_back('{rd: !wr, val: (wr ? d : exp_rd), cyc: cyc + 1 + w});
        @(negedge clk);
        dbg_we = 1'b0;
        addr   = ~a;
        we     = !wr;
        for (int i = 0; i < 40 && !rdy_v[sel]; i++) @(negedge clk);
        chk("ready_seen", rdy_v[sel], 1);
        if (wr) chk("dbg_after_write", drd_v[sel], d);
        @(negedge clk);
        chk("ready_held", rdy_v[sel], 1);
        mem_req = 1'b0;
        tb_doe  = 1'b0;
        @(negedge clk);
        chk("ready_dropped", rdy_v[sel], 0);
        tb_dq  = 8'h5A;
        tb_doe = 1'b1;
        #1 chk("bus_released", dobs_v[sel], 8'h5A);
        tb_doe = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("reset_ready", rdy_v[k], 0);
            chk("reset_abort", abort_v[k], 0);
        end
        tb_dq  = 8'h5A;
        tb_doe = 1'b1;
        #1 chk("reset_bus_released", dobs_v[0], 8'h5A);
        tb_doe = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Preload and read, zero wait states
        dbg_write(0, 8'h10, 8'hA5);
        access(0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 8'h00);

        // Write with three wait states
        access(3, 1'b1, 8'hE0, 8'h01, 8'h00, 1'b0, 8'h00);

        // Abort two cycles into a four-wait-state write
        dbg_write(4, 8'h20, 8'h9C);
        @(negedge clk);
        addr    = 8'h20;
        we      = 1'b1;
        tb_dq   = 8'h55;
        tb_doe  = 1'b1;
        mem_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_req = 1'b0;
        tb_doe  = 1'b0;
        @(negedge clk);
        chk("abort_set", abort_v[3], 1);
        chk("abort_no_ready", rdy_v[3], 0);
        chk("abort_no_write", drd_v[3], 8'h9C);
        access(4, 1'b0, 8'h20, 8'h00, 8'h9C, 1'b0, 8'h00);
        chk("abort_sticky", abort_v[3], 1);

        // Collisions between a bus commit and a debug write at one edge
        access(0, 1'b1, 8'h30, 8'h11, 8'h00, 1'b1, 8'h22);
        access(0, 1'b0, 8'h30, 8'h00, 8'h11, 1'b1, 8'h44);
        chk("collide_read_then_dbg", drd_v[0], 8'h44);

        // Reset while holding a read in READY
        sel = 0;
        @(negedge clk);
        addr    = 8'h10;
        we      = 1'b0;
        mem_req = 1'b1;
        sb.push_back('{rd: 1'b1, val: 8'hA5, cyc: cyc + 1});
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_ready_dropped", rdy_v[0], 0);
        tb_dq  = 8'h5A;
        tb_doe = 1'b1;
        #1 chk("rst_bus_released", dobs_v[0], 8'h5A);
        chk("rst_abort_cleared", abort_v[3], 0);
        tb_doe  = 1'b0;
        mem_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a five-wait-state write
        dbg_write(5, 8'h40, 8'h3E);
        @(negedge clk);
        addr    = 8'h40;
        we      = 1'b1;
        tb_dq   = 8'h77;
        tb_doe  = 1'b1;
        mem_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_wait_ready", rdy_v[4], 0);
        @(negedge clk);
        mem_req = 1'b0;
        tb_doe  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_no_commit", drd_v[4], 8'h3E);
        access(5, 1'b0, 8'h40, 8'h00, 8'h3E, 1'b0, 8'h00);

        // Fibonacci store sequence, then readback and wrap-edge address
        access(2, 1'b1, 8'hE0, 8'd1, 8'h00, 1'b0, 8'h00);
        access(2, 1'b1, 8'hE0, 8'd1, 8'h00, 1'b0, 8'h00);
        access(2, 1'b1, 8'hE0, 8'd2, 8'h00, 1'b0, 8'h00);
        access(2, 1'b1, 8'hE0, 8'd3, 8'h00, 1'b0, 8'h00);
        access(2, 1'b1, 8'hE0, 8'd5, 8'h00, 1'b0, 8'h00);
        access(2, 1'b1, 8'hE0, 8'd8, 8'h00, 1'b0, 8'h00);
        access(2, 1'b0, 8'hE0, 8'h00, 8'd8, 1'b0, 8'h00);
        dbg_write(2, 8'hFF, 8'hC3);
        access(2, 1'b0, 8'hFF, 8'h00, 8'hC3, 1'b0, 8'h00);
        chk("fib_no_abort", abort_v[1], 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
